// File: rtl/ether_tx_sched.sv
// Round-robin Ethernet TX frame scheduler.
// Grants one collector channel per frame, emits the 802.3 header
// (destination MAC, source MAC, 16-bit length), streams the granted
// channel's payload straight through, then zero-pads short payloads up to
// the minimum payload size. Preamble and CRC are left to the downstream MAC.
module ether_tx_sched #(
  parameter int N_REQ   = 4,
  parameter int MIN_PAY = 46,
  parameter int MAX_PAY = 1500
) (
  input  logic               i_clk125,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*11-1:0] i_len,
  input  logic [N_REQ*8-1:0] i_data,
  input  logic [N_REQ-1:0]   i_dval,
  output logic [N_REQ-1:0]   o_rdy,
  output logic [N_REQ-1:0]   o_gnt,
  input  logic [47:0]        i_desmac,
  input  logic [47:0]        i_soumac,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_dval,
  output logic               o_tx_sop,
  output logic               o_tx_eop,
  input  logic               i_tx_rdy,
  output logic               o_busy,
  output logic               o_len_err,
  output logic [15:0]        o_frame_cnt
);

  localparam int          PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [10:0] MIN_L = 11'(MIN_PAY);
  localparam logic [10:0] MAX_L = 11'(MAX_PAY);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_DES, S_SOU, S_LEN, S_DATA, S_PAD, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;        // last winner; doubles as the granted index
  logic [47:0]   des_sh;     // destination MAC, shifted out MSB first
  logic [47:0]   sou_sh;     // source MAC, shifted out MSB first
  logic [10:0]   len_q;      // latched payload length L
  logic [10:0]   cnt;        // byte index within the current field
  logic [15:0]   frame_cnt;

  logic [10:0]   len_arr  [N_REQ];
  logic [7:0]    data_arr [N_REQ];
  logic          found;
  logic [PW-1:0] winner;
  int            idx;
  logic          tx_fire;
  logic          last_data;
  logic          last_pad;

  // Unpack the flat per-requester buses into arrays for clean indexing.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      len_arr[i]  = i_len[11*i +: 11];
      data_arr[i] = i_data[8*i +: 8];
    end
  end

  // Round-robin search: first pending request after the last winner.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && i_req[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign tx_fire   = o_tx_dval & i_tx_rdy;
  assign last_data = (cnt == len_q - 11'd1);
  assign last_pad  = (cnt == MIN_L - 11'd1);

  // State register.
  always_ff @(posedge i_clk125 or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; header, payload and pad advance only on accepted bytes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (|i_req) state_nxt = S_ARB;
      S_ARB: begin
        if (!found || len_arr[winner] > MAX_L) state_nxt = S_IDLE;
        else                                   state_nxt = S_DES;
      end
      S_DES:  if (tx_fire && cnt == 11'd5) state_nxt = S_SOU;
      S_SOU:  if (tx_fire && cnt == 11'd5) state_nxt = S_LEN;
      S_LEN:  if (tx_fire && cnt == 11'd1) state_nxt = (len_q == '0) ? S_PAD : S_DATA;
      S_DATA: if (tx_fire && last_data)    state_nxt = (len_q >= MIN_L) ? S_DONE : S_PAD;
      S_PAD:  if (tx_fire && last_pad)     state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: grant pointer, latched header fields, byte counter, frame count.
  always_ff @(posedge i_clk125 or posedge i_rst) begin
    if (i_rst) begin
      ptr       <= PW'(N_REQ - 1);
      des_sh    <= '0;
      sou_sh    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_ARB: begin
          if (found) begin
            ptr    <= winner;
            des_sh <= i_desmac;
            sou_sh <= i_soumac;
            len_q  <= len_arr[winner];
            cnt    <= '0;
          end
        end
        S_DES: begin
          if (tx_fire) begin
            des_sh <= {des_sh[39:0], 8'h00};
            cnt    <= (cnt == 11'd5) ? '0 : cnt + 11'd1;
          end
        end
        S_SOU: begin
          if (tx_fire) begin
            sou_sh <= {sou_sh[39:0], 8'h00};
            cnt    <= (cnt == 11'd5) ? '0 : cnt + 11'd1;
          end
        end
        S_LEN: begin
          if (tx_fire) cnt <= (cnt == 11'd1) ? '0 : cnt + 11'd1;
        end
        // Pad continues counting from L, so it ends at index MIN_PAY-1.
        S_DATA, S_PAD: begin
          if (tx_fire) cnt <= cnt + 11'd1;
        end
        S_DONE: frame_cnt <= frame_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_frame_cnt = frame_cnt;

  // Output decode from state; header bytes depend only on registers, so they
  // stay stable while the MAC stalls.
  always_comb begin
    o_gnt     = '0;
    o_rdy     = '0;
    o_tx_data = '0;
    o_tx_dval = 1'b0;
    o_tx_sop  = 1'b0;
    o_tx_eop  = 1'b0;
    o_len_err = 1'b0;
    o_busy    = (state != S_IDLE);
    case (state)
      S_ARB: begin
        if (found) begin
          o_gnt     = N_REQ'(1) << winner;
          o_len_err = (len_arr[winner] > MAX_L);
        end
      end
      S_DES: begin
        o_gnt     = N_REQ'(1) << ptr;
        o_tx_dval = 1'b1;
        o_tx_data = des_sh[47:40];
        o_tx_sop  = (cnt == '0);
      end
      S_SOU: begin
        o_gnt     = N_REQ'(1) << ptr;
        o_tx_dval = 1'b1;
        o_tx_data = sou_sh[47:40];
      end
      S_LEN: begin
        o_gnt     = N_REQ'(1) << ptr;
        o_tx_dval = 1'b1;
        o_tx_data = cnt[0] ? len_q[7:0] : {5'b0, len_q[10:8]};
      end
      S_DATA: begin
        o_gnt      = N_REQ'(1) << ptr;
        o_rdy[ptr] = i_tx_rdy;
        o_tx_dval  = i_dval[ptr];
        o_tx_data  = data_arr[ptr];
        o_tx_eop   = last_data && (len_q >= MIN_L);
      end
      S_PAD: begin
        o_gnt     = N_REQ'(1) << ptr;
        o_tx_dval = 1'b1;
        o_tx_eop  = last_pad;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ether_tx_sched.sv
// Directed bench for ether_tx_sched: a table of frame scenarios with
// hand-computed grant and frame size, plus hand-written sequences for the
// length-error reject and reset in the middle of a frame.
module tb_ether_tx_sched;

  localparam int N    = 4;
  localparam int MINP = 46;

  typedef struct {
    logic [N-1:0] req;
    logic [10:0]  len;
    int           nframes;
    bit           rdy_toggle;
    bit           dval_gap;
    int           exp_first;
    int           exp_size;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, dval, rdy, gnt;
  logic [N*11-1:0] len;
  logic [N*8-1:0] data;
  logic [47:0]    des_mac, sou_mac;
  logic [7:0]     tx_data;
  logic           tx_dval, tx_sop, tx_eop, tx_rdy;
  logic           busy, len_err;
  logic [15:0]    frame_cnt;

  int         n_vec = 0;
  int         n_bad = 0;
  int         src_idx [N];
  int         src_len [N];
  bit         rdy_toggle = 1'b0;
  bit         dval_gap   = 1'b0;
  int         cyc = 0;
  int         fc_m = 0;
  logic [7:0] cap [$];
  bit         sop_q [$];
  vec_t       vecs [7];

  ether_tx_sched #(.N_REQ(N), .MIN_PAY(MINP), .MAX_PAY(1500)) dut (
    .i_clk125    (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_len       (len),
    .i_data      (data),
    .i_dval      (dval),
    .o_rdy       (rdy),
    .o_gnt       (gnt),
    .i_desmac    (des_mac),
    .i_soumac    (sou_mac),
    .o_tx_data   (tx_data),
    .o_tx_dval   (tx_dval),
    .o_tx_sop    (tx_sop),
    .o_tx_eop    (tx_eop),
    .i_tx_rdy    (tx_rdy),
    .o_busy      (busy),
    .o_len_err   (len_err),
    .o_frame_cnt (frame_cnt)
  );

  initial forever #4 clk = ~clk;

  function automatic logic [7:0] pay(input int r, input int k);
    return 8'((161 + 16 * r + k) % 256);
  endfunction

  function automatic int next_from(input int prev, input logic [N-1:0] rq);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (prev + k) % N;
      if (rq[i]) return i;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MAC backpressure and payload sources, driven just after each rising edge.
  initial begin
    tx_rdy = 1'b1;
    dval   = '0;
    data   = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_rdy = rdy_toggle ? cyc[0] : 1'b1;
      for (int r = 0; r < N; r++) begin
        dval[r]        = (src_idx[r] < src_len[r]) && !(dval_gap && (cyc % 3 == 1));
        data[8*r +: 8] = pay(r, src_idx[r]);
      end
    end
  end

  // Source read pointers advance on each accepted payload byte.
  initial begin
    forever begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (!gnt[r])                 src_idx[r] = 0;
        else if (dval[r] && rdy[r])  src_idx[r]++;
      end
    end
  end

  task automatic check_frame(input string tag, input int r, input int l, input int exp_size);
    logic [7:0] q [$];
    int n, bi, nsop;
    for (int i = 0; i < 6; i++) q.push_back(des_mac[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) q.push_back(sou_mac[8*(5-i) +: 8]);
    q.push_back(8'(l >> 8));
    q.push_back(8'(l));
    for (int k = 0; k < l; k++) q.push_back(pay(r, k));
    while (q.size() < 14 + MINP) q.push_back(8'h00);
    check({tag, " size"}, 64'(cap.size()), 64'(exp_size));
    n  = (cap.size() < q.size()) ? cap.size() : q.size();
    bi = -1;
    for (int i = 0; i < n; i++) if (bi < 0 && cap[i] !== q[i]) bi = i;
    if (bi < 0) bi = n - 1;
    check($sformatf("%s byte[%0d]", tag, bi), 64'(cap[bi]), 64'(q[bi]));
    nsop = 0;
    foreach (sop_q[i]) if (sop_q[i]) nsop++;
    check({tag, " sop count"}, 64'(nsop), 64'd1);
    check({tag, " sop on byte 0"}, 64'(sop_q[0]), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int got, cycles, w, prev_w, gnt_err, leg_err, stab_err;
    bit prev_stall;
    logic [7:0] pd;
    logic ps, pe;
    logic [N-1:0] cur;
    got = 0; cycles = 0; w = 0; prev_w = -1;
    gnt_err = 0; leg_err = 0; stab_err = 0;
    prev_stall = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0; cur = '0;
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (v.req[r]) begin
        len[11*r +: 11] = v.len;
        src_len[r]      = int'(v.len);
      end else begin
        src_len[r] = 0;
      end
    end
    rdy_toggle = v.rdy_toggle;
    dval_gap   = v.dval_gap;
    req        = v.req;
    cap.delete();
    sop_q.delete();
    while (got < v.nframes && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (((gnt & ~req) != '0) || ((rdy & ~gnt) != '0) || !$onehot0(gnt)) leg_err++;
      if (prev_stall && tx_dval && (tx_data !== pd || tx_sop !== ps || tx_eop !== pe)) stab_err++;
      prev_stall = tx_dval && !tx_rdy;
      pd = tx_data; ps = tx_sop; pe = tx_eop;
      if (cap.size() > 0 && gnt !== cur) gnt_err++;
      if (tx_dval && tx_rdy) begin
        if (cap.size() == 0) begin
          w   = (prev_w < 0) ? v.exp_first : next_from(prev_w, v.req);
          cur = N'(1) << w;
          check($sformatf("%s f%0d grant", tag, got), 64'(gnt), 64'(cur));
          prev_w = w;
        end
        cap.push_back(tx_data);
        sop_q.push_back(tx_sop);
        if (tx_eop) begin
          check_frame($sformatf("%s f%0d", tag, got), w, int'(v.len), v.exp_size);
          got++;
          cap.delete();
          sop_q.delete();
        end
      end
    end
    check({tag, " frames completed"}, 64'(got), 64'(v.nframes));
    @(posedge clk);
    #1;
    req = '0;
    repeat (4) @(negedge clk);
    fc_m += v.nframes;
    check({tag, " busy after frame"}, 64'(busy), 64'd0);
    check({tag, " frame_cnt"}, 64'(frame_cnt), 64'(fc_m));
    check({tag, " gnt/rdy legality"}, 64'(leg_err), 64'd0);
    check({tag, " gnt held in frame"}, 64'(gnt_err), 64'd0);
    check({tag, " stable under stall"}, 64'(stab_err), 64'd0);
  endtask

  initial begin
    int   seen, cycles, ndval, npulse, ngnt, nb, neop;
    logic [N-1:0] gat;
    vec_t pv;

    rst     = 1'b1;
    req     = '0;
    len     = '0;
    des_mac = 48'h02_11_22_33_44_55;
    sou_mac = 48'h02_AA_BB_CC_DD_EE;

    //           req      len      frames toggle gap first size
    vecs[0] = '{4'b0001, 11'd3,   1, 1'b0, 1'b0, 0, 60};
    vecs[1] = '{4'b0100, 11'd100, 1, 1'b0, 1'b0, 2, 114};
    vecs[2] = '{4'b0011, 11'd46,  4, 1'b0, 1'b0, 0, 60};
    vecs[3] = '{4'b0001, 11'd3,   1, 1'b1, 1'b1, 0, 60};
    vecs[4] = '{4'b0010, 11'd0,   1, 1'b0, 1'b0, 1, 60};
    vecs[5] = '{4'b1000, 11'd45,  1, 1'b1, 1'b0, 3, 60};
    vecs[6] = '{4'b0100, 11'd47,  1, 1'b0, 1'b1, 2, 61};

    repeat (3) @(negedge clk);
    check("reset outputs", 64'({busy, gnt, rdy, tx_dval, tx_sop, tx_eop, len_err, tx_data, frame_cnt}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Oversize request from requester 3: one-cycle reject, no bytes.
    @(posedge clk);
    #1;
    len[33 +: 11] = 11'd1600;
    for (int r = 0; r < N; r++) src_len[r] = 0;
    rdy_toggle = 1'b0;
    dval_gap   = 1'b0;
    req        = 4'b1000;
    seen = 0; cycles = 0; ndval = 0; gat = '0;
    while (seen == 0 && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (tx_dval) ndval++;
      if (len_err) begin
        seen = 1;
        gat  = gnt;
      end
    end
    check("len_err pulse seen", 64'(seen), 64'd1);
    check("len_err grant", 64'(gat), 64'b1000);
    @(posedge clk);
    #1;
    req = '0;
    npulse = 0; ngnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (len_err)    npulse++;
      if (gnt != '0)  ngnt++;
      if (tx_dval)    ndval++;
    end
    check("len_err single cycle", 64'(npulse), 64'd0);
    check("len_err grant dropped", 64'(ngnt), 64'd0);
    check("len_err no bytes", 64'(ndval), 64'd0);
    check("len_err frame_cnt", 64'(frame_cnt), 64'(fc_m));

    for (int i = 4; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while payload byte 20 of a 100-byte frame is on the bus.
    @(posedge clk);
    #1;
    len[11 +: 11] = 11'd100;
    for (int r = 0; r < N; r++) src_len[r] = (r == 1) ? 100 : 0;
    req = 4'b0010;
    nb = 0; neop = 0; cycles = 0;
    while (nb < 34 && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (tx_dval && tx_rdy) begin
        nb++;
        if (tx_eop) neop++;
      end
    end
    #1 rst = 1'b1;
    #1;
    check("abort point reached", 64'(nb), 64'd34);
    check("abort no eop", 64'(neop), 64'd0);
    check("reset mid-frame outputs", 64'({busy, gnt, rdy, tx_dval, tx_sop, tx_eop, len_err, tx_data, frame_cnt}), 64'd0);
    req = '0;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    fc_m = 0;
    pv = '{4'b0011, 11'd3, 1, 1'b0, 1'b0, 0, 60};
    run_vec(pv, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
